ula_div_ctrl: RTL and testbench
===============================

# ula_div_ctrl

Sequencing controller that drives one 32-bit ripple subtractor (`full_adder_32bit_sub`) through a 32-iteration restoring division, producing an unsigned quotient and remainder. It sits beside the ULA datapath as a multi-cycle functional unit. Operands come in through a valid/ready handshake, and results go out through a second valid/ready handshake. The subtractor is the only arithmetic element; this block owns all shift, compare and restore sequencing around it.

## Interface
- Parameters: none. Width is fixed at 32 by the subtractor.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operands present.
- `in_ready` out 1: high only in IDLE.
- `dividend` in 32: unsigned.
- `divisor` in 32: unsigned.
- `out_valid` out 1: result held.
- `out_ready` in 1: consumer accepts.
- `quotient` out 32: result.
- `remainder` out 32: result.
- `div_by_zero` out 1: qualifies the current result.
- `busy` out 1: high in CALC.

## Operation
- States: IDLE, CALC, DONE.
- IDLE→CALC on `in_valid && in_ready` with `divisor != 0`:
  - latch divisor D and dividend into Q;
  - R=0;
  - cnt=31.
- IDLE→DONE on accept with `divisor == 0`:
  - quotient=32'hFFFFFFFF;
  - remainder=dividend;
  - div_by_zero=1.
- CALC, one bit per cycle:
  - trial = {R[30:0], Q[31]}; carry bit c = R[31].
  - Subtractor computes trial − D; `carry_out` = 1 means no borrow.
  - ge = c | carry_out. This covers the 33-bit shifted remainder when D ≥ 2^31; the mod-2^32 difference is exact in that case.
  - R ← ge ? diff : trial.
  - Q ← {Q[30:0], ge}.
  - cnt ← cnt−1.
  - When cnt==0: go to DONE, quotient=Q, remainder=R, div_by_zero=0.
- DONE:
  - `out_valid`=1.
  - On `out_ready`: go to IDLE, clear `out_valid`.
  - Outputs stay constant while `out_valid && !out_ready`.
- Subtractor `overflow` output is unused.
- `in_valid` is ignored outside IDLE. Operands need only be stable in the accept cycle.

## Timing
- Reset values (async, immediate):
  - state=IDLE, cnt=0, R=Q=D=0;
  - quotient=remainder=0;
  - out_valid=0, div_by_zero=0, busy=0;
  - `in_ready`=1 (decoded from IDLE).
  - Inputs are not sampled while `rst_n`=0.
- Latency, normal case: accept at edge E0; 32 CALC edges E1..E32; `out_valid` visible after E32.
- Latency, divide by zero: `out_valid` visible after E0.
- DONE→IDLE on the edge where `out_ready`=1. `in_ready` rises the following cycle; no accept in the same cycle as result consumption.
- Minimum initiation interval: 34 cycles (normal), 2 cycles (div-by-zero).
- `out_valid` must not drop without a handshake.
- Reset mid-CALC or mid-DONE:
  - abandons the operation;
  - no partial result is ever presented;
  - the first post-reset accept behaves as from clean state.
- `out_ready` in IDLE or CALC has no effect.
- Outputs come from registers, except `in_ready` and `busy`, which are state decodes. There is no combinational path from inputs to outputs.

## Structure
- Shared package `ula_pkg` holds:
  - state encoding: IDLE=2'd0, CALC=2'd1, DONE=2'd2;
  - `DIV_ITER`=32;
  - `DIV0_QUOT`=32'hFFFFFFFF.
- One sub-module instance: `full_adder_32bit_sub`, with a=trial and b=D.
- Everything else is one FSM plus datapath registers in this module.

## Test plan
- 100 / 7 → quotient=14, remainder=2, div_by_zero=0; `out_valid` rises exactly 32 cycles after accept.
- 32'hFFFFFFFF / 32'h80000001 → quotient=1, remainder=32'h7FFFFFFE. This exercises the R[31] carry path.
- 5 / 0 → one cycle after accept: quotient=32'hFFFFFFFF, remainder=5, div_by_zero=1; `busy` never asserts.
- 32'hFFFFFFFF / 1 with `out_ready` held low for 10 cycles → quotient=32'hFFFFFFFF and remainder=0, both stable throughout; `in_ready`=0 until the cycle after `out_ready`=1.
- Pulse `rst_n` low at CALC cycle 15 of 1000/3 → all outputs reach reset values immediately and `in_ready`=1; a following 9/4 gives quotient=2, remainder=1.
- Back-to-back 0/9 then 9/9 with `out_ready` tied high → results (0,0) then (1,0), with a 34-cycle spacing.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the ULA multi-cycle functional units.
package ula_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int          DIV_ITER  = 32;
    localparam int          CNT_W     = 5;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

    // Iteration counter value loaded at accept; counts down to zero.
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(DIV_ITER - 1);

endpackage

// File: rtl/full_adder_32bit_sub.sv
// 32-bit subtractor: diff = a - b, computed as a + ~b + 1.
// carry_out = 1 means no borrow (a >= b unsigned); overflow is the signed overflow flag.
module full_adder_32bit_sub (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] diff,
    output logic        carry_out,
    output logic        overflow
);

    logic [32:0] sum_ext;

    // Two's-complement subtraction with the carry chain kept one bit wider.
    always_comb begin
        sum_ext   = {1'b0, a} + {1'b0, ~b} + 33'd1;
        diff      = sum_ext[31:0];
        carry_out = sum_ext[32];
        overflow  = (a[31] ^ b[31]) & (sum_ext[31] ^ a[31]);
    end

endmodule

// File: rtl/ula_div_ctrl.sv
// Restoring 32-bit unsigned divider sequencer around a single subtractor.
// One quotient bit per cycle; valid/ready handshakes on operands and results.
module ula_div_ctrl
    import ula_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero,
    output logic        busy
);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      r_q, r_d;
    logic [31:0]      q_q, q_d;
    logic [31:0]      d_q, d_d;
    logic [31:0]      quot_q, quot_d;
    logic [31:0]      rem_q, rem_d;
    logic             out_valid_q, out_valid_d;
    logic             dbz_q, dbz_d;

    logic [31:0]      trial;
    logic [31:0]      sub_diff;
    logic             sub_carry;
    logic             sub_overflow_unused;
    logic             ge;

    // Shift the next dividend bit into the partial remainder; R[31] is the
    // 33rd bit that falls off and must still count toward the compare.
    assign trial = {r_q[30:0], q_q[31]};
    assign ge    = r_q[31] | sub_carry;

    full_adder_32bit_sub u_sub (
        .a         (trial),
        .b         (d_q),
        .diff      (sub_diff),
        .carry_out (sub_carry),
        .overflow  (sub_overflow_unused)
    );

    // Next-state and datapath updates; every register holds by default.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (divisor != 32'd0) begin
                        state_d = CALC;
                        d_d     = divisor;
                        q_d     = dividend;
                        r_d     = 32'd0;
                        cnt_d   = CNT_START;
                    end else begin
                        state_d     = DONE;
                        quot_d      = DIV0_QUOT;
                        rem_d       = dividend;
                        dbz_d       = 1'b1;
                        out_valid_d = 1'b1;
                    end
                end
            end
            CALC: begin
                r_d   = ge ? sub_diff : trial;
                q_d   = {q_q[30:0], ge};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    cnt_d       = '0;
                    quot_d      = {q_q[30:0], ge};
                    rem_d       = ge ? sub_diff : trial;
                    dbz_d       = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            dbz_q       <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q == CALC);
    assign out_valid   = out_valid_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_ula_div_ctrl.sv
// Directed self-checking bench for the restoring divider sequencer.
module tb_ula_div_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        busy;

    int n_checks;
    int n_fail;

    ula_div_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair for a single accept edge, then wait for out_valid.
    // lat = number of edges after the accept edge until out_valid is seen.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic busy_seen);
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        dividend  = 32'hDEAD_BEEF;
        divisor   = 32'h0;
        lat       = 0;
        busy_seen = busy;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
            busy_seen = busy_seen | busy;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({out_valid, div_by_zero, busy, in_ready} !== 4'b0001 ||
            quotient !== 32'd0 || remainder !== 32'd0) begin
            n_fail++;
            $display("FAIL reset: ov=%b dbz=%b busy=%b rdy=%b q=%h r=%h, want 0 0 0 1 0 0",
                     out_valid, div_by_zero, busy, in_ready, quotient, remainder);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        $display("reset: ov=%b rdy=%b q=%h r=%h", out_valid, in_ready, quotient, remainder);
    endtask

    task automatic test_basic();
        int   lat;
        logic bs;
        run_op(32'd100, 32'd7, lat, bs);
        $display("op 100/7: lat=%0d q=%0d r=%0d dbz=%b", lat, quotient, remainder, div_by_zero);
        n_checks++;
        if (lat !== 32) begin n_fail++; $display("FAIL basic_latency: got %0d want 32", lat); end
        n_checks++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: q=%0d r=%0d dbz=%b want 14 2 0", quotient, remainder, div_by_zero);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_in_ready_done: got %b want 0", in_ready); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_consume: ov=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_carry_path();
        int   lat;
        logic bs;
        run_op(32'hFFFF_FFFF, 32'h8000_0001, lat, bs);
        $display("op FFFFFFFF/80000001: lat=%0d q=%h r=%h", lat, quotient, remainder);
        n_checks++;
        if (quotient !== 32'd1 || remainder !== 32'h7FFF_FFFE) begin
            n_fail++;
            $display("FAIL carry_result: q=%h r=%h want 00000001 7ffffffe", quotient, remainder);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_div_zero();
        int   lat;
        logic bs;
        run_op(32'd5, 32'd0, lat, bs);
        $display("op 5/0: lat=%0d q=%h r=%0d dbz=%b busy_seen=%b", lat, quotient, remainder, div_by_zero, bs);
        n_checks++;
        if (lat !== 0) begin n_fail++; $display("FAIL div0_latency: got %0d want 0", lat); end
        n_checks++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd5 || div_by_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL div0_result: q=%h r=%0d dbz=%b want ffffffff 5 1", quotient, remainder, div_by_zero);
        end
        n_checks++;
        if (bs !== 1'b0) begin n_fail++; $display("FAIL div0_busy: got %b want 0", bs); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL div0_consume: ov=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_hold();
        int   lat;
        logic bs;
        run_op(32'hFFFF_FFFF, 32'd1, lat, bs);
        $display("op FFFFFFFF/1: lat=%0d q=%h r=%h", lat, quotient, remainder);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                quotient !== 32'hFFFF_FFFF || remainder !== 32'd0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: ov=%b rdy=%b q=%h r=%h want 1 0 ffffffff 0",
                         i, out_valid, in_ready, quotient, remainder);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: ov=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_calc();
        int   lat;
        logic bs;
        dividend = 32'd1000;
        divisor  = 32'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, div_by_zero, busy, in_ready} !== 4'b0001 ||
            quotient !== 32'd0 || remainder !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: ov=%b dbz=%b busy=%b rdy=%b q=%h r=%h want 0 0 0 1 0 0",
                     out_valid, div_by_zero, busy, in_ready, quotient, remainder);
        end
        tick();
        rst_n = 1'b1;
        tick();
        run_op(32'd9, 32'd4, lat, bs);
        $display("op 9/4 after reset: lat=%0d q=%0d r=%0d", lat, quotient, remainder);
        n_checks++;
        if (lat !== 32 || quotient !== 32'd2 || remainder !== 32'd1) begin
            n_fail++;
            $display("FAIL midrst_next_op: lat=%0d q=%0d r=%0d want 32 2 1", lat, quotient, remainder);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int          acc_cyc[2];
        logic [31:0] res_q[2];
        logic [31:0] res_r[2];
        int          n_acc;
        int          n_res;
        logic        busy_prev;
        out_ready = 1'b1;
        dividend  = 32'd0;
        divisor   = 32'd9;
        in_valid  = 1'b1;
        n_acc     = 0;
        n_res     = 0;
        busy_prev = busy;
        for (int i = 1; i <= 120 && n_res < 2; i++) begin
            tick();
            if (busy && !busy_prev && n_acc < 2) begin
                acc_cyc[n_acc] = i;
                n_acc++;
                if (n_acc == 1) begin
                    dividend = 32'd9;
                    divisor  = 32'd9;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid && n_res < 2) begin
                res_q[n_res] = quotient;
                res_r[n_res] = remainder;
                $display("b2b result %0d: cycle=%0d q=%0d r=%0d", n_res, i, quotient, remainder);
                n_res++;
            end
            busy_prev = busy;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (n_acc != 2 || n_res != 2) begin
            n_fail++;
            $display("FAIL b2b_count: accepts=%0d results=%0d want 2 2", n_acc, n_res);
        end else begin
            n_checks++;
            if (acc_cyc[1] - acc_cyc[0] != 34) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d want 34", acc_cyc[1] - acc_cyc[0]);
            end
            n_checks++;
            if (res_q[0] !== 32'd0 || res_r[0] !== 32'd0) begin
                n_fail++;
                $display("FAIL b2b_first: q=%0d r=%0d want 0 0", res_q[0], res_r[0]);
            end
            n_checks++;
            if (res_q[1] !== 32'd1 || res_r[1] !== 32'd0) begin
                n_fail++;
                $display("FAIL b2b_second: q=%0d r=%0d want 1 0", res_q[1], res_r[1]);
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        test_reset();
        test_basic();
        test_carry_path();
        test_div_zero();
        test_hold();
        test_reset_mid_calc();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
